// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and packed-matrix helpers for the 3x3
// systolic array front end.
package systolic_pkg;
  localparam int DIM        = 3;
  localparam int FEED_STEPS = 2*DIM-1;
  localparam int STEP_W     = $clog2(FEED_STEPS);

  typedef logic [STEP_W-1:0] step_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } feed_state_e;

  // LSB of element [r][c] in a row-major packed DIM x DIM matrix of ew-bit elements.
  function automatic int elem_lsb(input int r, input int c, input int ew);
    return (DIM*r + c) * ew;
  endfunction
endpackage

// File: rtl/systolic_skew_lane.sv
// One edge lane of the feeder: picks the element for wavefront step_i,
// or zero when this lane is outside the diagonal band.
module systolic_skew_lane
  import systolic_pkg::*;
#(
  parameter int N = 31
) (
  input  step_t      step_i,
  input  logic [1:0] lane_i,
  input  logic [N:0] e0_i,
  input  logic [N:0] e1_i,
  input  logic [N:0] e2_i,
  output logic [N:0] elem_o
);
  int d;

  always_comb begin
    d      = int'(step_i) - int'(lane_i);
    elem_o = '0;
    case (d)
      0:       elem_o = e0_i;
      1:       elem_o = e1_i;
      2:       elem_o = e2_i;
      default: elem_o = '0;
    endcase
  end
endmodule

// File: rtl/systolic_input_feeder.sv
// Captures A and B in one handshake, streams them skewed into the array edges,
// then waits for the array to drain and pulses done.
module systolic_input_feeder
  import systolic_pkg::*;
#(
  parameter int N            = 31,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [9*(N+1)-1:0] a_mat,
  input  logic [9*(N+1)-1:0] b_mat,
  output logic               busy,
  output logic [N:0]         a0,
  output logic [N:0]         a1,
  output logic [N:0]         a2,
  output logic [N:0]         b0,
  output logic [N:0]         b1,
  output logic [N:0]         b2,
  output logic               feed_valid,
  output logic               done,
  output feed_state_e        state_dbg
);
  localparam int W  = N + 1;
  localparam int MW = DIM*DIM*W;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Handshake: start is sampled on a posedge and accepted only in IDLE;
  // an accepted start puts step 0 on the edges in the very next cycle.
  feed_state_e   state_q, state_d;
  step_t         step_q, step_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [MW-1:0] a_q, b_q, src_a, src_b;
  logic [W-1:0]  a_out_q [DIM];
  logic [W-1:0]  b_out_q [DIM];
  logic [W-1:0]  a_lane [DIM];
  logic [W-1:0]  b_lane [DIM];
  logic          fv_q, busy_q, done_q;
  logic          accept, fv_d, done_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_FEED;
          step_d  = '0;
        end
      end
      ST_FEED: begin
        if (step_q == STEP_W'(FEED_STEPS-1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES-1)) state_d = ST_IDLE;
        else                                drain_d = drain_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // On the accept edge the lanes read the input bus directly so step 0 is not delayed.
    src_a  = accept ? a_mat : a_q;
    src_b  = accept ? b_mat : b_q;
    fv_d   = (state_d == ST_FEED);
    done_d = (state_d == ST_DRAIN) && (drain_d == DW'(DRAIN_CYCLES-1));
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    systolic_skew_lane #(.N(N)) u_a_lane (
      .step_i (step_d),
      .lane_i (2'(i)),
      .e0_i   (src_a[elem_lsb(i, 0, W) +: W]),
      .e1_i   (src_a[elem_lsb(i, 1, W) +: W]),
      .e2_i   (src_a[elem_lsb(i, 2, W) +: W]),
      .elem_o (a_lane[i])
    );
    systolic_skew_lane #(.N(N)) u_b_lane (
      .step_i (step_d),
      .lane_i (2'(i)),
      .e0_i   (src_b[elem_lsb(0, i, W) +: W]),
      .e1_i   (src_b[elem_lsb(1, i, W) +: W]),
      .e2_i   (src_b[elem_lsb(2, i, W) +: W]),
      .elem_o (b_lane[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        a_out_q[i] <= '0;
        b_out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      if (accept) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      fv_q   <= fv_d;
      busy_q <= (state_d != ST_IDLE);
      done_q <= done_d;
      for (int i = 0; i < DIM; i++) begin
        a_out_q[i] <= fv_d ? a_lane[i] : '0;
        b_out_q[i] <= fv_d ? b_lane[i] : '0;
      end
    end
  end

  assign a0         = a_out_q[0];
  assign a1         = a_out_q[1];
  assign a2         = a_out_q[2];
  assign b0         = b_out_q[0];
  assign b1         = b_out_q[1];
  assign b2         = b_out_q[2];
  assign feed_valid = fv_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for the systolic input feeder, including a small
// output-stationary PE grid to check the end-to-end product.
module tb_systolic_input_feeder;
  import systolic_pkg::*;

  localparam int N            = 31;
  localparam int W            = N + 1;
  localparam int DRAIN_CYCLES = 3;

  typedef int           mat9_t [9];
  typedef logic [W-1:0] vec3_t [3];

  logic           clock = 1'b0;
  logic           reset, start, pe_clr;
  logic [9*W-1:0] a_mat, b_mat;
  logic           busy, feed_valid, done;
  logic [W-1:0]   a0, a1, a2, b0, b1, b2;
  feed_state_e    state_dbg;

  int total = 0;
  int bad   = 0;

  systolic_input_feeder #(.N(N), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .a_mat      (a_mat),
    .b_mat      (b_mat),
    .busy       (busy),
    .a0         (a0),
    .a1         (a1),
    .a2         (a2),
    .b0         (b0),
    .b1         (b1),
    .b2         (b2),
    .feed_valid (feed_valid),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Reference PE grid: a flows east, b flows south, c accumulates a*b.
  logic [W-1:0] fa [3];
  logic [W-1:0] fb [3];
  logic [W-1:0] pa [3][3];
  logic [W-1:0] pb [3][3];
  logic [W-1:0] pc [3][3];
  assign fa[0] = a0; assign fa[1] = a1; assign fa[2] = a2;
  assign fb[0] = b0; assign fb[1] = b1; assign fb[2] = b2;

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (pe_clr) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          pc[i][j] <= '0;
        end else begin
          pa[i][j] <= (j == 0) ? fa[i] : pa[i][j-1];
          pb[i][j] <= (i == 0) ? fb[j] : pb[i-1][j];
          pc[i][j] <= pc[i][j] + ((j == 0) ? fa[i] : pa[i][j-1]) * ((i == 0) ? fb[j] : pb[i-1][j]);
        end
      end
    end
  end

  // checking
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_edges(input string tag, input vec3_t ea, input vec3_t eb, input logic efv);
    chk({tag, " a0"}, 64'(a0), 64'(ea[0]));
    chk({tag, " a1"}, 64'(a1), 64'(ea[1]));
    chk({tag, " a2"}, 64'(a2), 64'(ea[2]));
    chk({tag, " b0"}, 64'(b0), 64'(eb[0]));
    chk({tag, " b1"}, 64'(b1), 64'(eb[1]));
    chk({tag, " b2"}, 64'(b2), 64'(eb[2]));
    chk({tag, " fv"}, 64'(feed_valid), 64'(efv));
  endtask

  // drivers
  function automatic logic [9*W-1:0] pack9(input mat9_t e);
    logic [9*W-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*W +: W] = W'(e[i]);
    return r;
  endfunction

  task automatic kick(input logic [9*W-1:0] am, input logic [9*W-1:0] bm, input logic clr);
    a_mat  = am;
    b_mat  = bm;
    start  = 1'b1;
    pe_clr = clr;
    @(negedge clock);
    start  = 1'b0;
    pe_clr = 1'b0;
  endtask

  localparam logic [W-1:0] F = '1;
  vec3_t          z3;
  vec3_t          sk_a [5];
  vec3_t          sk_b [5];
  vec3_t          band [5];
  logic [9*W-1:0] mat_a, mat_i, mat_b2;
  logic [W-1:0]   exp_c [9];
  int             ndone;

  initial begin
    if (DRAIN_CYCLES < 1) begin
      $display("FAIL cfg DRAIN_CYCLES=%0d must be at least 1", DRAIN_CYCLES);
      $fatal(1, "configuration error");
    end
  end

  initial begin
    z3      = '{32'd0, 32'd0, 32'd0};
    sk_a[0] = '{32'd1, 32'd0, 32'd0}; sk_b[0] = '{32'd1, 32'd0, 32'd0};
    sk_a[1] = '{32'd2, 32'd4, 32'd0}; sk_b[1] = '{32'd0, 32'd0, 32'd0};
    sk_a[2] = '{32'd3, 32'd5, 32'd7}; sk_b[2] = '{32'd0, 32'd1, 32'd0};
    sk_a[3] = '{32'd0, 32'd6, 32'd8}; sk_b[3] = '{32'd0, 32'd0, 32'd0};
    sk_a[4] = '{32'd0, 32'd0, 32'd9}; sk_b[4] = '{32'd0, 32'd0, 32'd1};
    band[0] = '{F, 32'd0, 32'd0};
    band[1] = '{F, F, 32'd0};
    band[2] = '{F, F, F};
    band[3] = '{32'd0, F, F};
    band[4] = '{32'd0, 32'd0, F};
    exp_c   = '{32'd30, 32'd24, 32'd18, 32'd84, 32'd69, 32'd54, 32'd138, 32'd114, 32'd90};
    mat_a   = pack9('{1, 2, 3, 4, 5, 6, 7, 8, 9});
    mat_i   = pack9('{1, 0, 0, 0, 1, 0, 0, 0, 1});
    mat_b2  = pack9('{9, 8, 7, 6, 5, 4, 3, 2, 1});

    reset = 1'b1; start = 1'b0; pe_clr = 1'b0; a_mat = '0; b_mat = '0;
    repeat (2) @(negedge clock);
    chk_edges("rst", z3, z3, 1'b0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b0;
    @(negedge clock);

    // basic skew: A, B = identity
    kick(mat_a, mat_i, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk_edges($sformatf("skew k%0d", k), sk_a[k], sk_b[k], 1'b1);
      chk($sformatf("skew k%0d busy", k), 64'(busy), 64'd1);
      chk($sformatf("skew k%0d done", k), 64'(done), 64'd0);
      @(negedge clock);
    end
    for (int c = 6; c <= 9; c++) begin
      chk_edges($sformatf("tail t+%0d", c), z3, z3, 1'b0);
      chk($sformatf("tail t+%0d busy", c), 64'(busy), 64'(c <= 8));
      chk($sformatf("tail t+%0d done", c), 64'(done), 64'(c == 8));
      @(negedge clock);
    end

    // full chain, with an ignored start at t+3 carrying other matrices
    kick(mat_a, mat_b2, 1'b1);
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) ndone++;
      if (c == 4) chk_edges("busy_start t+4", '{32'd0, 32'd6, 32'd8}, '{32'd0, 32'd2, 32'd4}, 1'b1);
      if (c == 8) begin
        chk("chain done", 64'(done), 64'd1);
        for (int i = 0; i < 9; i++)
          chk($sformatf("chain c%0d%0d", i/3, i%3), 64'(pc[i/3][i%3]), 64'(exp_c[i]));
      end
      if (c == 3) begin
        a_mat = pack9('{5, 5, 5, 5, 5, 5, 5, 5, 5});
        b_mat = pack9('{5, 5, 5, 5, 5, 5, 5, 5, 5});
        start = 1'b1;
      end
      if (c == 4) start = 1'b0;
      @(negedge clock);
    end
    chk("busy_start ndone", 64'(ndone), 64'd1);
    chk("busy_start idle", 64'(busy), 64'd0);

    // back-to-back with start held high
    a_mat = mat_a; b_mat = mat_i; start = 1'b1;
    @(negedge clock);
    for (int c = 1; c <= 18; c++) begin
      chk($sformatf("b2b t+%0d fv", c), 64'(feed_valid), 64'((c >= 1 && c <= 5) || (c >= 10 && c <= 14)));
      chk($sformatf("b2b t+%0d busy", c), 64'(busy), 64'((c >= 1 && c <= 8) || (c >= 10 && c <= 17)));
      chk($sformatf("b2b t+%0d done", c), 64'(done), 64'(c == 8 || c == 17));
      if (c == 10) chk("b2b second a0", 64'(a0), 64'd1);
      if (c == 18) start = 1'b0;
      @(negedge clock);
    end
    @(negedge clock);

    // asynchronous reset in the middle of a stream
    kick(mat_a, mat_i, 1'b0);
    repeat (2) @(negedge clock);
    chk_edges("mid t+3", sk_a[2], sk_b[2], 1'b1);
    #1 reset = 1'b1;
    #1;
    chk_edges("async rst", z3, z3, 1'b0);
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || busy) ndone++;
      @(negedge clock);
    end
    chk("post rst quiet", 64'(ndone), 64'd0);
    kick(mat_a, mat_i, 1'b0);
    chk_edges("clean t+1", sk_a[0], sk_b[0], 1'b1);
    repeat (2) @(negedge clock);
    chk_edges("clean t+3", sk_a[2], sk_b[2], 1'b1);
    repeat (5) @(negedge clock);
    chk("clean done", 64'(done), 64'd1);
    repeat (2) @(negedge clock);

    // full-width elements
    kick(pack9('{-1, -1, -1, -1, -1, -1, -1, -1, -1}), pack9('{-1, -1, -1, -1, -1, -1, -1, -1, -1}), 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk_edges($sformatf("wide k%0d", k), band[k], band[k], 1'b1);
      @(negedge clock);
    end
    chk_edges("wide tail", z3, z3, 1'b0);
    repeat (5) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
